// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants, FSM state type and an elaboration-time helper for the
// iterative binary-to-BCD converter.
package bin2bcd_seq_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;  // bits per BCD digit
  localparam int unsigned ADJ_THRESH  = 5;  // digits at or above this get corrected
  localparam int unsigned ADJ_CORR    = 3;  // double-dabble correction value

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  // 10**n as a wide constant, used only to validate parameters at elaboration.
  function automatic logic [127:0] pow10(input int unsigned n);
    logic [127:0] r;
    r = 128'(1);
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 128'(10);
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake bundle between a requester and bin2bcd_seq.
// Signals: start, bin (requester -> converter); busy, done, bcd, lead_zero
// (converter -> requester). master = requester side, slave = converter side.
interface bin2bcd_seq_if
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = 20,
  parameter int unsigned DIGITS = 7
) ();

  logic                          start;
  logic [BIN_W-1:0]              bin;
  logic                          busy;
  logic                          done;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]             lead_zero;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  lead_zero
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output lead_zero
  );

endinterface

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// Combinational double-dabble cell: adds 3 to a BCD digit that is >= 5 so the
// following left shift carries correctly into the next decimal digit.
// Ports: digit_i (4-bit scratch digit), adj_c_o (corrected digit, no carry out).
module bcd_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] adj_c_o
);

  always_comb begin
    adj_c_o = digit_i;
    if (digit_i >= BCD_DIGIT_W'(ADJ_THRESH)) begin
      adj_c_o = digit_i + BCD_DIGIT_W'(ADJ_CORR);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 converter from an unsigned binary value to packed BCD
// digits, one bit per clock. Ports: clk, rst_n (synchronous, active-low) and
// the slave side of bin2bcd_seq_if (start/bin in, busy/done/bcd/lead_zero out).
// bcd and lead_zero hold their value between done pulses.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = 20,
  parameter int unsigned DIGITS = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  bus
);

  localparam int unsigned SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [DIGITS-1:0] LZ_RST   = {{(DIGITS-1){1'b1}}, 1'b0};
  localparam logic [127:0]      BIN_MAX  = (128'(1) << BIN_W) - 128'(1);

  // Refuse to elaborate if DIGITS cannot hold the largest input value.
  if (pow10(DIGITS) <= BIN_MAX) begin : g_param_err
    $error("bin2bcd_seq: DIGITS too small for BIN_W");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [BIN_W-1:0]   sh_q,    sh_d;
  logic [SCR_W-1:0]   scr_q,   scr_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic [SCR_W-1:0]   bcd_q,   bcd_d;
  logic [DIGITS-1:0]  lz_q,    lz_d;

  logic [SCR_W-1:0]   scr_adj;
  logic [SCR_W-1:0]   scr_shift;
  logic [DIGITS-1:0]  lz_calc;

  // Per-digit add-3 correction of the current scratch value.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scr_q  [BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .adj_c_o (scr_adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  // Corrected scratch shifted left with the next binary bit entering at bit 0.
  assign scr_shift = {scr_adj[SCR_W-2:0], sh_q[BIN_W-1]};

  // Leading-zero flags of the post-iteration value; digit 0 is never blanked.
  always_comb begin
    logic all_zero;
    lz_calc  = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (scr_shift[BCD_DIGIT_W*i +: BCD_DIGIT_W] != '0) begin
        all_zero = 1'b0;
      end
      lz_calc[i] = all_zero;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      scr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      lz_q    <= LZ_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      lz_q    <= lz_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    lz_d    = lz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sh_d    = bus.bin;
          scr_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        scr_d = scr_shift;
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        // The last iteration's result goes straight to the outputs.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_d   = scr_shift;
          lz_d    = lz_calc;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bcd       = bcd_q;
  assign bus.lead_zero = lz_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: the driver pushes the decimal-arithmetic
// expectation for every accepted conversion, the monitor pops on each done.
module tb_bin2bcd_seq;

  localparam int unsigned BIN_W  = 20;
  localparam int unsigned DIGITS = 7;

  typedef struct packed {
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   lz;
  } exp_t;

  logic clk;
  logic rst_n;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  int   done_cycs[$];

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: digits by decimal division, blanking by magnitude.
  function automatic exp_t model(input int unsigned v);
    exp_t r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r.bcd[4*i +: 4] = 4'((v / p) % 10);
      r.lz[i]         = (i > 0) && (v < p);
      p               = p * 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each done against the scoreboard, and checks hold.
  initial begin
    logic                r;
    logic [4*DIGITS-1:0] prev_bcd;
    logic [DIGITS-1:0]   prev_lz;
    exp_t                e;
    prev_bcd = '0;
    prev_lz  = '0;
    forever begin
      @(posedge clk);
      r = rst_n;
      #1;
      cyc++;
      if (r) begin
        if (bus.done) begin
          done_cycs.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("bcd", 64'(bus.bcd), 64'(e.bcd));
            check("lead_zero", 64'(bus.lead_zero), 64'(e.lz));
          end
        end else if (bus.bcd !== prev_bcd || bus.lead_zero !== prev_lz) begin
          check("hold_bcd", 64'(bus.bcd), 64'(prev_bcd));
          check("hold_lz", 64'(bus.lead_zero), 64'(prev_lz));
        end
      end
      prev_bcd = bus.bcd;
      prev_lz  = bus.lead_zero;
    end
  end

  // One conversion from IDLE, checking busy/done timing along the way.
  task automatic convert(input logic [BIN_W-1:0] v);
    bus.start = 1'b1;
    bus.bin   = v;
    exp_q.push_back(model(int'(v)));
    tick();
    bus.start = 1'b0;
    bus.bin   = BIN_W'($urandom);
    check("busy_first", 64'(bus.busy), 64'(1));
    for (int j = 2; j <= int'(BIN_W); j++) begin
      tick();
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        check("busy_window", 64'({bus.busy, bus.done}), 64'(2'b10));
      end
    end
    tick();
    check("done_pulse", 64'({bus.busy, bus.done}), 64'(2'b01));
  endtask

  initial begin
    int base;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    tick();
    tick();
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_bcd", 64'(bus.bcd), 64'(0));
    check("rst_lz", 64'(bus.lead_zero), 64'(7'b1111110));
    rst_n = 1'b1;
    tick();

    // Directed boundary values.
    convert(20'd0);
    convert(20'd1048575);
    convert(20'd12345);

    // Back-to-back with start held high.
    bus.start = 1'b1;
    bus.bin   = 20'd999;
    exp_q.push_back(model(999));
    tick();
    for (int j = 0; j < int'(BIN_W); j++) tick();
    check("b2b_done1", 64'(bus.done), 64'(1));
    bus.bin = 20'd1000;
    exp_q.push_back(model(1000));
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < int'(BIN_W); j++) tick();
    check("b2b_done2", 64'(bus.done), 64'(1));
    if (done_cycs.size() >= 2) begin
      check("b2b_gap", 64'(done_cycs[done_cycs.size()-1] - done_cycs[done_cycs.size()-2]),
            64'(BIN_W + 1));
    end else begin
      check("b2b_done_count", 64'(done_cycs.size()), 64'(2));
    end

    // Start and bin changes while busy are ignored.
    tick();
    bus.start = 1'b1;
    bus.bin   = 20'd42;
    exp_q.push_back(model(42));
    tick();
    bus.start = 1'b0;
    for (int j = 2; j <= 7; j++) tick();
    bus.start = 1'b1;
    bus.bin   = 20'd5;
    for (int j = 8; j <= 19; j++) tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("busy_chg_done", 64'(bus.done), 64'(1));
    for (int j = 0; j < 25; j++) tick();
    check("busy_chg_no_extra", 64'(exp_q.size()), 64'(0));

    // Reset in the middle of a conversion.
    bus.start = 1'b1;
    bus.bin   = 20'd777;
    tick();
    bus.start = 1'b0;
    for (int j = 2; j <= 10; j++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_done", 64'(bus.done), 64'(0));
    check("midrst_bcd", 64'(bus.bcd), 64'(0));
    check("midrst_lz", 64'(bus.lead_zero), 64'(7'b1111110));
    base = done_cycs.size();
    for (int j = 0; j < 25; j++) tick();
    check("midrst_no_done", 64'(done_cycs.size()), 64'(base));
    convert(20'd777);

    // Randomized conversions with random idle gaps.
    for (int n = 0; n < 30; n++) begin
      convert(BIN_W'($urandom_range(0, (1 << BIN_W) - 1)));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
    end

    for (int j = 0; j < 5; j++) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
